// File: rtl/seq_gen_serial.sv
// Serial pattern transmitter.
// Sends a PAT_W-bit pattern MSB-first, one bit per clock, repeat_n times,
// with gap_n idle cycles between copies. Every output comes from a register,
// and dout is forced low whenever dout_vld is low. The transfer settings
// are captured at start, so later changes on the inputs do not affect a
// transfer that is already running.

module seq_gen_serial #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_n,
  input  logic [GAP_W-1:0] gap_n,
  output logic             dout,
  output logic             dout_vld,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pat_cnt
);

  localparam int IDX_W = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_W - 1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t             state_r, state_s;
  logic [PAT_W-1:0]   pat_r, pat_s;
  logic [CNT_W-1:0]   rep_r, rep_s;
  logic [GAP_W-1:0]   gap_r, gap_s;
  logic [IDX_W-1:0]   bit_idx_r, bit_idx_s;
  logic [GAP_W-1:0]   gap_cnt_r, gap_cnt_s;
  logic [CNT_W-1:0]   pat_cnt_r, pat_cnt_s;
  logic               dout_r, dout_s;
  logic               dout_vld_r, dout_vld_s;
  logic               busy_r, busy_s;
  logic               done_r, done_s;

  // Count value once the copy currently on the wire is complete.
  logic [CNT_W-1:0]   cnt_inc_s;
  // Index of the bit that follows the current one within a copy.
  logic [IDX_W-1:0]   idx_dec_s;

  assign cnt_inc_s = pat_cnt_r + CNT_ONE;
  assign idx_dec_s = bit_idx_r - IDX_ONE;

  // Next-state and next-output logic; the registered outputs present the
  // state that the next clock edge enters.
  always_comb begin
    state_s    = state_r;
    pat_s      = pat_r;
    rep_s      = rep_r;
    gap_s      = gap_r;
    bit_idx_s  = bit_idx_r;
    gap_cnt_s  = gap_cnt_r;
    pat_cnt_s  = pat_cnt_r;
    dout_s     = 1'b0;
    dout_vld_s = 1'b0;
    busy_s     = 1'b0;
    done_s     = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          pat_s     = pattern;
          rep_s     = repeat_n;
          gap_s     = gap_n;
          pat_cnt_s = '0;
          bit_idx_s = IDX_MSB;
          gap_cnt_s = '0;
          if (repeat_n == '0) begin
            state_s = ST_DONE;
            done_s  = 1'b1;
          end else begin
            state_s    = ST_SEND;
            dout_s     = pattern[PAT_W-1];
            dout_vld_s = 1'b1;
            busy_s     = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_SEND: begin
        if (bit_idx_r == '0) begin
          // Last bit of this copy is on the wire now.
          pat_cnt_s = cnt_inc_s;
          if (cnt_inc_s == rep_r) begin
            state_s = ST_DONE;
            done_s  = 1'b1;
          end else if (gap_r != '0) begin
            state_s   = ST_GAP;
            gap_cnt_s = gap_r - GAP_ONE;
            busy_s    = 1'b1;
          end else begin
            state_s    = ST_SEND;
            bit_idx_s  = IDX_MSB;
            dout_s     = pat_r[PAT_W-1];
            dout_vld_s = 1'b1;
            busy_s     = 1'b1;
          end
        end else begin
          state_s    = ST_SEND;
          bit_idx_s  = idx_dec_s;
          dout_s     = pat_r[idx_dec_s];
          dout_vld_s = 1'b1;
          busy_s     = 1'b1;
        end
      end

      ST_GAP: begin
        if (gap_cnt_r == '0) begin
          state_s    = ST_SEND;
          bit_idx_s  = IDX_MSB;
          dout_s     = pat_r[PAT_W-1];
          dout_vld_s = 1'b1;
          busy_s     = 1'b1;
        end else begin
          state_s   = ST_GAP;
          gap_cnt_s = gap_cnt_r - GAP_ONE;
          busy_s    = 1'b1;
        end
      end

      ST_DONE: begin
        state_s = ST_IDLE;
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // Abort overrides whatever the case above decided, but keeps the
    // partial copy count visible.
    if (abort) begin
      state_s    = ST_IDLE;
      pat_cnt_s  = pat_cnt_r;
      dout_s     = 1'b0;
      dout_vld_s = 1'b0;
      busy_s     = 1'b0;
      done_s     = 1'b0;
    end else begin
      state_s = state_s;
    end
  end

  // State, captured settings, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      pat_r      <= '0;
      rep_r      <= '0;
      gap_r      <= '0;
      bit_idx_r  <= '0;
      gap_cnt_r  <= '0;
      pat_cnt_r  <= '0;
      dout_r     <= 1'b0;
      dout_vld_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      pat_r      <= pat_s;
      rep_r      <= rep_s;
      gap_r      <= gap_s;
      bit_idx_r  <= bit_idx_s;
      gap_cnt_r  <= gap_cnt_s;
      pat_cnt_r  <= pat_cnt_s;
      dout_r     <= dout_s;
      dout_vld_r <= dout_vld_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
    end
  end

  assign dout     = dout_r;
  assign dout_vld = dout_vld_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign pat_cnt  = pat_cnt_r;

  seq_gen_serial_chk u_chk (
    .clk      (clk),
    .rst      (rst),
    .dout     (dout_r),
    .dout_vld (dout_vld_r),
    .busy     (busy_r),
    .done     (done_r)
  );

endmodule

// Output invariants of the transmitter.
module seq_gen_serial_chk (
  input logic clk,
  input logic rst,
  input logic dout,
  input logic dout_vld,
  input logic busy,
  input logic done
);

  // The data line stays low outside valid bits.
  a_dout_quiet: assert property (@(posedge clk) disable iff (rst) !dout_vld |-> !dout);

  // A valid bit is only ever sent while busy.
  a_vld_busy: assert property (@(posedge clk) disable iff (rst) dout_vld |-> busy);

  // done is a single-cycle pulse outside the busy window.
  a_done_idle: assert property (@(posedge clk) disable iff (rst) done |-> !busy);
  a_done_pulse: assert property (@(posedge clk) disable iff (rst) done |=> !done);

endmodule
